// File: rtl/ex_mem.sv
// rtl/ex_mem.sv - EX/MEM pipeline register with flush/hold/bubble control.
// MADD_MSUB_EN enables the multiply-accumulate feedback registers (hilo_o, cnt_o).
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef DoubleRegBus
`define DoubleRegBus 63:0
`endif

module ex_mem (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stall,
  input  logic                 flush,
  input  logic [`RegAddrBus]   ex_wd,
  input  logic                 ex_wreg,
  input  logic [`RegBus]       ex_wdata,
  input  logic [`RegBus]       ex_hi,
  input  logic [`RegBus]       ex_lo,
  input  logic                 ex_whilo,
  input  logic [`DoubleRegBus] hilo_i,
  input  logic [1:0]           cnt_i,
  output logic [`RegAddrBus]   mem_wd,
  output logic                 mem_wreg,
  output logic [`RegBus]       mem_wdata,
  output logic [`RegBus]       mem_hi,
  output logic [`RegBus]       mem_lo,
  output logic                 mem_whilo,
  output logic                 mem_valid,
  output logic [`DoubleRegBus] hilo_o,
  output logic [1:0]           cnt_o
);

  logic [`RegAddrBus] wd_q, wd_d;
  logic               wreg_q, wreg_d;
  logic [`RegBus]     wdata_q, wdata_d;
  logic [`RegBus]     hi_q, hi_d;
  logic [`RegBus]     lo_q, lo_d;
  logic               whilo_q, whilo_d;
  logic               valid_q, valid_d;

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};

  // Priority: flush > hold (MEM stalled) > bubble (EX stalled) > capture.
  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    valid_d = valid_q;
    if (flush || (!stall[4] && stall[3])) begin
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
      hi_d    = '0;
      lo_d    = '0;
      whilo_d = 1'b0;
      valid_d = 1'b0;
    end else if (!stall[4]) begin
      wd_d    = ex_wd;
      wreg_d  = ex_wreg;
      wdata_d = ex_wdata;
      hi_d    = ex_hi;
      lo_d    = ex_lo;
      whilo_d = ex_whilo;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
      valid_q <= valid_d;
    end
  end

  assign mem_wd    = wd_q;
  assign mem_wreg  = wreg_q;
  assign mem_wdata = wdata_q;
  assign mem_hi    = hi_q;
  assign mem_lo    = lo_q;
  assign mem_whilo = whilo_q;
  assign mem_valid = valid_q;

`ifdef MADD_MSUB_EN
  logic [`DoubleRegBus] hilo_q, hilo_d;
  logic [1:0]           cnt_q, cnt_d;

  // Accumulate state survives only while EX is stalled; a real issue restarts it.
  always_comb begin
    hilo_d = hilo_q;
    cnt_d  = cnt_q;
    if (flush) begin
      hilo_d = '0;
      cnt_d  = 2'b00;
    end else if (!stall[4]) begin
      hilo_d = stall[3] ? hilo_i : '0;
      cnt_d  = stall[3] ? cnt_i  : 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo_q <= '0;
      cnt_q  <= 2'b00;
    end else begin
      hilo_q <= hilo_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hilo_o = hilo_q;
  assign cnt_o  = cnt_q;
`else
  logic unused_acc;
  assign unused_acc = ^{hilo_i, cnt_i};
  assign hilo_o     = '0;
  assign cnt_o      = 2'b00;
`endif

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have parameter-free port list; widths fixed by `RegBus (32), `RegAddrBus (5), `DoubleRegBus (64).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately, independent of clk.
REQ-004 stall  input  6  pipeline stall vector; bit 3 = EX stalled, bit 4 = MEM stalled.
REQ-005 flush  input  1  discard in-flight instruction.
REQ-006 ex_wd / ex_wreg / ex_wdata  input  5/1/32  destination address, write enable and result from EX.
REQ-007 ex_hi / ex_lo / ex_whilo  input  32/32/1  HI/LO write request from EX.
REQ-008 hilo_i / cnt_i  input  64/2  partial multiply-accumulate product and cycle count from EX.
REQ-009 mem_wd / mem_wreg / mem_wdata  output  5/1/32  registered copy to MEM.
REQ-010 mem_hi / mem_lo / mem_whilo  output  32/32/1  registered HI/LO request to MEM.
REQ-011 mem_valid  output  1  slot holds a real (non-bubble) instruction.
REQ-012 hilo_o / cnt_o  output  64/2  held accumulate state fed back to EX.

Function
REQ-013 All outputs SHALL be registers; EX-to-MEM latency exactly one cycle.
REQ-014 Update priority per edge: flush > hold > bubble > capture.
REQ-015 flush=1: all mem_* outputs, mem_valid, hilo_o, cnt_o SHALL load 0, regardless of stall.
REQ-016 Hold (stall[4]=1): every output SHALL retain its value; this includes the illegal stall[3]=0 combination.
REQ-017 Bubble (stall[3]=1, stall[4]=0): mem_* outputs and mem_valid load 0; hilo_o<=hilo_i, cnt_o<=cnt_i.
REQ-018 Capture (stall[3]=0, stall[4]=0): mem_* <= ex_* field-for-field, mem_valid<=1, hilo_o<=0, cnt_o<=0.
REQ-019 A bubble SHALL never assert mem_wreg or mem_whilo.
REQ-020 cnt semantics: 2'b00 idle, 2'b01 first accumulate cycle done, 2'b10 result ready; values pass unmodified, no arithmetic in block.
REQ-021 Consecutive bubbles SHALL keep refreshing hilo_o/cnt_o from inputs every cycle.
REQ-022 Reset deassertion mid-stall: first edge after rst=1 follows REQ-014 from reset state.

Reset
REQ-023 rst=0 SHALL asynchronously force mem_wd=0, mem_wreg=0, mem_wdata=0, mem_hi=0, mem_lo=0, mem_whilo=0, mem_valid=0, hilo_o=0, cnt_o=0.
REQ-024 Outputs SHALL remain at reset values while rst=0 regardless of clk, stall or flush.

Configuration
REQ-025 Macro MADD_MSUB_EN SHALL gate the multiply-accumulate feedback path.
REQ-026 Defined: hilo_o/cnt_o registers implemented per REQ-015..REQ-021.
REQ-027 Undefined: hilo_o and cnt_o tied to 0 constantly, hilo_i/cnt_i ignored; all other behaviour unchanged.

Verification
REQ-028 Capture: ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h0000_1234, stall=0 -> next edge mem_wd=3, mem_wreg=1, mem_wdata=32'h1234, mem_valid=1.
REQ-029 Bubble with accumulate: stall=6'b001111, hilo_i=64'h0000_0001_FFFF_FFFE, cnt_i=2'b01, ex_wreg=1 -> mem_wreg=0, mem_valid=0, hilo_o=64'h0000_0001_FFFF_FFFE, cnt_o=2'b01 (MADD_MSUB_EN defined); hilo_o=0, cnt_o=0 when undefined.
REQ-030 Hold: load mem_wdata=32'hDEAD_BEEF, then stall=6'b011111 for 3 cycles with ex_wdata=32'h1 -> mem_wdata stays 32'hDEAD_BEEF, mem_valid stays 1.
REQ-031 Flush priority: mem_valid=1, stall=6'b011111, flush=1 -> next edge all outputs 0.
REQ-032 Async reset: rst pulsed 0 between edges with mem_whilo=1, mem_hi=32'hFFFF_FFFF -> outputs 0 before next edge, remain 0 until first edge after rst=1.
REQ-033 Accumulate release: after REQ-029 bubble, stall=0 with ex_whilo=1, ex_hi=32'h2 -> mem_hi=2, mem_whilo=1, hilo_o=0, cnt_o=0.
